// File: rtl/spi_mcp_master_if.sv
// Command/status and SPI pin bundle for the MCP23S17-style SPI initiator.
// The master modport is the view taken by the initiator itself; the slave
// modport is the view of whatever drives commands and models the SPI sink.
interface spi_mcp_master_if;
    logic       start;
    logic       rw;
    logic [2:0] dev_addr;
    logic [7:0] reg_addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       sclk_o;
    logic       csn_o;
    logic       mosi_o;
    logic       miso_i;

    modport master (
        input  start, rw, dev_addr, reg_addr, wdata, miso_i,
        output busy, done, rdata, sclk_o, csn_o, mosi_o
    );

    modport slave (
        output start, rw, dev_addr, reg_addr, wdata, miso_i,
        input  busy, done, rdata, sclk_o, csn_o, mosi_o
    );
endinterface

// File: rtl/spi_mcp_master.sv
// SPI mode-0 initiator issuing 24-bit MCP23S17 register frames:
// opcode {0100, A2..A0, R/W}, register address, data. On reads the third
// byte is captured from miso and presented on rdata at completion.
module spi_mcp_master #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 4
) (
    input  logic              clk,
    input  logic              rst,
    spi_mcp_master_if.master  bus
);

    generate
        if (CLK_DIV < 2) begin : g_bad_clk_div
            $error("spi_mcp_master: CLK_DIV must be >= 2");
        end
        if ((CS_SETUP < 1) || (CS_HOLD < 1) || (CS_IDLE < 1)) begin : g_bad_cs_timing
            $error("spi_mcp_master: CS_SETUP, CS_HOLD and CS_IDLE must be >= 1");
        end
    endgenerate

    localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
    localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
    localparam logic [15:0] IDLE_LAST  = 16'(CS_IDLE - 1);

    // 48 SCLK edges per frame; the last one is a falling edge.
    localparam logic [5:0]  LAST_EDGE  = 6'd47;
    // Rising edges of byte 3 are edge numbers 32, 34, ... 46.
    localparam logic [5:0]  BYTE3_EDGE = 6'd32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [5:0]  r_edge;
    logic [22:0] r_frame;     // bits still to be shifted, MSB next
    logic [7:0]  r_rx;
    logic        r_rw;
    logic        r_busy;
    logic        r_done;
    logic [7:0]  r_rdata;
    logic        r_sclk;
    logic        r_csn;
    logic        r_mosi;

    logic [23:0] w_frame;

    assign w_frame = {4'b0100, bus.dev_addr, bus.rw, bus.reg_addr, bus.wdata};

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.rdata  = r_rdata;
    assign bus.sclk_o = r_sclk;
    assign bus.csn_o  = r_csn;
    assign bus.mosi_o = r_mosi;

    // Frame sequencer: chip-select timing, SCLK generation, shifting and completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
            r_edge  <= 6'd0;
            r_frame <= 23'd0;
            r_rx    <= 8'h00;
            r_rw    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rdata <= 8'h00;
            r_sclk  <= 1'b0;
            r_csn   <= 1'b1;
            r_mosi  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_SETUP;
                        r_cnt   <= 16'd0;
                        r_edge  <= 6'd0;
                        r_frame <= w_frame[22:0];
                        r_mosi  <= w_frame[23];
                        r_rw    <= bus.rw;
                        r_csn   <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == SETUP_LAST) begin
                        r_state <= S_SHIFT;
                        r_cnt   <= 16'd0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt == DIV_LAST) begin
                        r_cnt  <= 16'd0;
                        r_edge <= r_edge + 6'd1;
                        if (!r_sclk) begin
                            // Rising edge: sink data has been stable since the previous fall.
                            r_sclk <= 1'b1;
                            if (r_rw && (r_edge >= BYTE3_EDGE)) begin
                                r_rx <= {r_rx[6:0], bus.miso_i};
                            end
                        end else begin
                            r_sclk <= 1'b0;
                            if (r_edge == LAST_EDGE) begin
                                // Last bit stays on mosi through the hold time.
                                r_state <= S_HOLD;
                            end else begin
                                r_mosi  <= r_frame[22];
                                r_frame <= {r_frame[21:0], 1'b0};
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_state <= S_GAP;
                        r_cnt   <= 16'd0;
                        r_csn   <= 1'b1;
                        r_mosi  <= 1'b0;
                        r_done  <= 1'b1;
                        if (r_rw) begin
                            r_rdata <= r_rx;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == IDLE_LAST) begin
                        r_state <= S_IDLE;
                        r_cnt   <= 16'd0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 16'd0;
                    r_sclk  <= 1'b0;
                    r_csn   <= 1'b1;
                    r_mosi  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mcp_master.sv
// Directed bench for spi_mcp_master: default-timing instance (A) and a
// fast-timing instance (B), each with a behavioural MCP23S17 read sink.
module tb_spi_mcp_master;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // Cycle index used by the monitors to time events.
    always @(posedge clk) cyc <= cyc + 1;

    spi_mcp_master_if ifa ();
    spi_mcp_master_if ifb ();

    spi_mcp_master #(.CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2), .CS_IDLE(4))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));

    spi_mcp_master #(.CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(1))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));

    // ---------------- SPI sink models: drive byte 3 after SCLK falls ----------------
    logic [7:0] td_a = 8'h00, sh_a = 8'h00;
    logic [7:0] td_b = 8'h00, sh_b = 8'h00;
    int         fcnt_a = 0, fcnt_b = 0;

    // Sink A: counts falling edges, presents td_a MSB first on byte 3.
    always @(negedge ifa.sclk_o or posedge ifa.csn_o) begin
        if (ifa.csn_o) begin
            fcnt_a = 0;
            ifa.miso_i = 1'b0;
        end else begin
            fcnt_a++;
            if (fcnt_a == 16) sh_a = td_a;
            if (fcnt_a >= 16 && fcnt_a < 24) begin
                ifa.miso_i = sh_a[7];
                sh_a = {sh_a[6:0], 1'b0};
            end
        end
    end

    // Sink B: same behaviour for the fast instance.
    always @(negedge ifb.sclk_o or posedge ifb.csn_o) begin
        if (ifb.csn_o) begin
            fcnt_b = 0;
            ifb.miso_i = 1'b0;
        end else begin
            fcnt_b++;
            if (fcnt_b == 16) sh_b = td_b;
            if (fcnt_b >= 16 && fcnt_b < 24) begin
                ifb.miso_i = sh_b[7];
                sh_b = {sh_b[6:0], 1'b0};
            end
        end
    end

    // ---------------- Monitors ----------------
    logic [23:0] a_mosi_cap = 24'd0;
    int          a_rises = 0;

    // Records mosi on every SCLK rising edge of instance A.
    always @(posedge ifa.sclk_o) begin
        a_mosi_cap = {a_mosi_cap[22:0], ifa.mosi_o};
        a_rises++;
    end

    logic prev_csn_a = 1'b1, prev_busy_a = 1'b0;
    int   a_frames = 0, a_last_fall = 0, a_last_rise = 0, a_low_len = 0;
    int   a_done_n = 0, a_done_cyc = 0, a_busy_fall = 0;
    logic [7:0] a_rdata_done = 8'h00;

    // Instance A event timing, sampled mid-cycle.
    always @(negedge clk) begin
        if (prev_csn_a && !ifa.csn_o) begin a_frames++; a_last_fall = cyc; end
        if (!prev_csn_a && ifa.csn_o) begin a_last_rise = cyc; a_low_len = cyc - a_last_fall; end
        if (ifa.done === 1'b1) begin a_done_n++; a_done_cyc = cyc; a_rdata_done = ifa.rdata; end
        if (prev_busy_a && !ifa.busy) a_busy_fall = cyc;
        prev_csn_a  = ifa.csn_o;
        prev_busy_a = ifa.busy;
    end

    logic prev_csn_b = 1'b1, prev_sclk_b = 1'b0;
    int   b_last_fall = 0, b_low_len = 0;
    int   b_rise_n = 0, b_rise_t0 = 0, b_rise_t1 = 0, b_fall_n = 0, b_fall_t0 = 0;

    // Instance B frame length and SCLK shape, sampled mid-cycle.
    always @(negedge clk) begin
        if (prev_csn_b && !ifb.csn_o) begin
            b_last_fall = cyc; b_rise_n = 0; b_fall_n = 0;
        end
        if (!prev_csn_b && ifb.csn_o) b_low_len = cyc - b_last_fall;
        if (!prev_sclk_b && ifb.sclk_o) begin
            if (b_rise_n == 0) b_rise_t0 = cyc;
            if (b_rise_n == 1) b_rise_t1 = cyc;
            b_rise_n++;
        end
        if (prev_sclk_b && !ifb.sclk_o) begin
            if (b_fall_n == 0) b_fall_t0 = cyc;
            b_fall_n++;
        end
        prev_csn_b  = ifb.csn_o;
        prev_sclk_b = ifb.sclk_o;
    end

    // ---------------- Stimulus helpers ----------------
    task automatic send_a(input logic rw, input logic [2:0] dev, input logic [7:0] ra, input logic [7:0] wd);
        @(posedge clk); #1;
        ifa.rw = rw; ifa.dev_addr = dev; ifa.reg_addr = ra; ifa.wdata = wd; ifa.start = 1'b1;
        @(posedge clk); #1;
        ifa.start = 1'b0;
    endtask

    task automatic send_b(input logic rw, input logic [2:0] dev, input logic [7:0] ra, input logic [7:0] wd);
        @(posedge clk); #1;
        ifb.rw = rw; ifb.dev_addr = dev; ifb.reg_addr = ra; ifb.wdata = wd; ifb.start = 1'b1;
        @(posedge clk); #1;
        ifb.start = 1'b0;
    endtask

    task automatic wait_idle_a(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (ifa.busy === 1'b0) begin ok = 1'b1; break; end
        end
        @(negedge clk); #1;
    endtask

    task automatic wait_idle_b(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (ifb.busy === 1'b0) begin ok = 1'b1; break; end
        end
        @(negedge clk); #1;
    endtask

    // ---------------- Tests ----------------
    task automatic test_reset();
        checks++; if (ifa.csn_o !== 1'b1)   begin failures++; $display("FAIL reset_csn: got %b want 1", ifa.csn_o); end
        checks++; if (ifa.sclk_o !== 1'b0)  begin failures++; $display("FAIL reset_sclk: got %b want 0", ifa.sclk_o); end
        checks++; if (ifa.mosi_o !== 1'b0)  begin failures++; $display("FAIL reset_mosi: got %b want 0", ifa.mosi_o); end
        checks++; if (ifa.busy !== 1'b0)    begin failures++; $display("FAIL reset_busy: got %b want 0", ifa.busy); end
        checks++; if (ifa.done !== 1'b0)    begin failures++; $display("FAIL reset_done: got %b want 0", ifa.done); end
        checks++; if (ifa.rdata !== 8'h00)  begin failures++; $display("FAIL reset_rdata: got %h want 00", ifa.rdata); end
        checks++; if (ifb.csn_o !== 1'b1)   begin failures++; $display("FAIL reset_b_csn: got %b want 1", ifb.csn_o); end
    endtask

    task automatic test_write();
        int d0 = a_done_n;
        int r0 = a_rises;
        bit ok;
        send_a(1'b0, 3'b001, 8'h0A, 8'h5C);
        checks++; if (ifa.csn_o !== 1'b0) begin failures++; $display("FAIL accept_csn: got %b want 0", ifa.csn_o); end
        checks++; if (ifa.busy !== 1'b1)  begin failures++; $display("FAIL accept_busy: got %b want 1", ifa.busy); end
        checks++; if (ifa.mosi_o !== 1'b0) begin failures++; $display("FAIL accept_mosi: got %b want 0", ifa.mosi_o); end
        wait_idle_a(400, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL write_timeout: got %b want 1", ok); end
        checks++; if (a_mosi_cap !== 24'h420A5C) begin failures++; $display("FAIL write_mosi: got %h want 420a5c", a_mosi_cap); end
        checks++; if (a_rises - r0 != 24) begin failures++; $display("FAIL write_rises: got %0d want 24", a_rises - r0); end
        checks++; if (a_low_len != 196) begin failures++; $display("FAIL write_csn_len: got %0d want 196", a_low_len); end
        checks++; if (a_done_n - d0 != 1) begin failures++; $display("FAIL write_done_cnt: got %0d want 1", a_done_n - d0); end
        checks++; if (ifa.rdata !== 8'h00) begin failures++; $display("FAIL write_rdata: got %h want 00", ifa.rdata); end
    endtask

    task automatic test_read(input logic [7:0] td, input logic [7:0] ra);
        int d0 = a_done_n;
        bit ok;
        td_a = td;
        send_a(1'b1, 3'b000, ra, 8'h00);
        wait_idle_a(400, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL read_timeout: got %b want 1", ok); end
        checks++; if (a_mosi_cap[23:8] !== {8'h41, ra}) begin failures++; $display("FAIL read_header: got %h want %h", a_mosi_cap[23:8], {8'h41, ra}); end
        checks++; if (a_rdata_done !== td) begin failures++; $display("FAIL read_rdata_done: got %h want %h", a_rdata_done, td); end
        checks++; if (ifa.rdata !== td) begin failures++; $display("FAIL read_rdata: got %h want %h", ifa.rdata, td); end
        checks++; if (a_busy_fall - a_done_cyc != 4) begin failures++; $display("FAIL read_busy_clear: got %0d want 4", a_busy_fall - a_done_cyc); end
        checks++; if (a_done_n - d0 != 1) begin failures++; $display("FAIL read_done_cnt: got %0d want 1", a_done_n - d0); end
    endtask

    task automatic test_back_to_back();
        int  f0 = a_frames;
        int  d0 = a_done_n;
        bit  seen = 1'b0;
        bit  ok;
        @(posedge clk); #1;
        ifa.rw = 1'b0; ifa.dev_addr = 3'b010; ifa.reg_addr = 8'h01; ifa.wdata = 8'h33; ifa.start = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk); #1;
            if (a_frames == f0 + 2) begin seen = 1'b1; break; end
        end
        ifa.start = 1'b0;
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL b2b_second_frame: got %b want 1", seen); end
        checks++; if (a_last_fall - a_last_rise != 5) begin failures++; $display("FAIL b2b_gap: got %0d want 5", a_last_fall - a_last_rise); end
        // Stray start pulses while the second frame is in flight.
        for (int k = 0; k < 3; k++) begin
            repeat (40) @(posedge clk);
            #1 ifa.start = 1'b1;
            @(posedge clk); #1 ifa.start = 1'b0;
        end
        // One more right on the done cycle.
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (ifa.done === 1'b1) begin seen = 1'b1; break; end
        end
        ifa.start = 1'b1;
        @(posedge clk); #1 ifa.start = 1'b0;
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL b2b_done_seen: got %b want 1", seen); end
        wait_idle_a(400, ok);
        repeat (30) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (a_frames != f0 + 2) begin failures++; $display("FAIL b2b_frames: got %0d want %0d", a_frames - f0, 2); end
        checks++; if (a_done_n - d0 != 2) begin failures++; $display("FAIL b2b_done_cnt: got %0d want 2", a_done_n - d0); end
        checks++; if (ifa.busy !== 1'b0) begin failures++; $display("FAIL b2b_idle: got %b want 0", ifa.busy); end
    endtask

    task automatic test_reset_mid();
        int d0 = a_done_n;
        int r0 = a_rises;
        bit seen = 1'b0;
        td_a = 8'hA5;
        send_a(1'b1, 3'b000, 8'h12, 8'h00);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (a_rises == r0 + 10) begin seen = 1'b1; break; end
        end
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL midrst_rises: got %0d want 10", a_rises - r0); end
        #2 rst = 1'b1;
        #1;
        checks++; if (ifa.csn_o !== 1'b1)  begin failures++; $display("FAIL midrst_csn: got %b want 1", ifa.csn_o); end
        checks++; if (ifa.sclk_o !== 1'b0) begin failures++; $display("FAIL midrst_sclk: got %b want 0", ifa.sclk_o); end
        checks++; if (ifa.busy !== 1'b0)   begin failures++; $display("FAIL midrst_busy: got %b want 0", ifa.busy); end
        @(negedge clk); rst = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (a_done_n != d0) begin failures++; $display("FAIL midrst_no_done: got %0d want 0", a_done_n - d0); end
        test_read(8'hA5, 8'h12);
    endtask

    task automatic test_fast();
        bit ok;
        td_b = 8'h3C;
        send_b(1'b1, 3'b101, 8'h09, 8'h00);
        wait_idle_b(300, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL fast_timeout: got %b want 1", ok); end
        checks++; if (b_low_len != 98) begin failures++; $display("FAIL fast_csn_len: got %0d want 98", b_low_len); end
        checks++; if (ifb.rdata !== 8'h3C) begin failures++; $display("FAIL fast_rdata: got %h want 3c", ifb.rdata); end
        checks++; if (b_rise_t1 - b_rise_t0 != 4) begin failures++; $display("FAIL fast_sclk_period: got %0d want 4", b_rise_t1 - b_rise_t0); end
        checks++; if (b_fall_t0 - b_rise_t0 != 2) begin failures++; $display("FAIL fast_sclk_high: got %0d want 2", b_fall_t0 - b_rise_t0); end
    endtask

    task automatic test_miso_edges();
        test_read(8'h80, 8'h13);
        test_read(8'h01, 8'h14);
    endtask

    initial begin
        rst = 1'b0;
        ifa.start = 1'b0; ifa.rw = 1'b0; ifa.dev_addr = 3'd0; ifa.reg_addr = 8'h00; ifa.wdata = 8'h00;
        ifb.start = 1'b0; ifb.rw = 1'b0; ifb.dev_addr = 3'd0; ifb.reg_addr = 8'h00; ifb.wdata = 8'h00;
        #1 rst = 1'b1;
        #2;
        test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        test_write();
        test_read(8'hA5, 8'h12);
        test_back_to_back();
        test_reset_mid();
        test_fast();
        test_miso_edges();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
